// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Takes the decoder's MemRead/MemWrite/MemUnit controls and carries out one
//   load or store per instruction as a valid/ready transaction on the data
//   memory bus. It generates the byte lanes, replicates store data across the
//   lanes, sign- or zero-extends load data, and stalls the core until the
//   access completes.
//
// Parameters
//   TIMEOUT     maximum number of cycles spent in ISSUE+WAIT_R before the
//               access is aborted; 0 disables the timeout
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high; returns the unit to IDLE
//   MemRead     load request from the decoder
//   MemWrite    store request from the decoder
//   MemUnit     access size: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   addr        byte address (ALU result)
//   wdata       store data (rs2)
//   rdata       extended load data, registered, held until the next load
//   stall       holds the PC/pipeline while high
//   misalign    misaligned or illegal access, one cycle, no bus activity
//   bus_err     timeout abort, one cycle, in DONE
//   bus_req     bus request
//   bus_we      1 write, 0 read
//   bus_addr    word-aligned address
//   bus_be      byte enables
//   bus_wdata   lane-replicated store data
//   bus_gnt     request accepted this cycle
//   bus_rvalid  read data valid
//   bus_rdata   read word
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemUnit,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [2:0]      r_unit;
  logic            r_we;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic            w_req;
  logic            w_misal;
  logic            w_timeout;
  logic            w_abort;
  logic            w_stall;
  logic            w_misalign;
  logic            w_bus_req;
  logic [3:0]      w_be;
  logic [31:0]     w_bwdata;
  logic [31:0]     w_sh;
  logic [31:0]     w_ext;

  assign w_req = MemRead | MemWrite;

  // Alignment / legality check on the incoming request.
  always_comb begin
    w_misal = 1'b0;
    case (MemUnit)
      3'd0, 3'd4: w_misal = 1'b0;
      3'd1, 3'd5: w_misal = addr[0];
      3'd2:       w_misal = (addr[1:0] != 2'b00);
      default:    w_misal = 1'b1;
    endcase
    if (MemRead && MemWrite) begin
      w_misal = 1'b1;
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  // Byte lanes and store-data replication from the latched request.
  always_comb begin
    w_be     = 4'b1111;
    w_bwdata = r_wdata;
    case (r_unit)
      3'd0, 3'd4: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_bwdata = {4{r_wdata[7:0]}};
      end
      3'd1, 3'd5: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_bwdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_bwdata = r_wdata;
      end
    endcase
  end

  // Load extraction; word accesses are aligned so w_sh equals bus_rdata.
  assign w_sh = bus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_unit)
      3'd0:    w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'd4:    w_ext = {24'h000000, w_sh[7:0]};
      3'd1:    w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
      3'd5:    w_ext = {16'h0000, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_misalign = 1'b0;
    w_bus_req  = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_misal) begin
            w_misalign = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_bus_req = 1'b1;
        w_stall   = 1'b1;
        // A completing write grant beats the timeout; a read grant does not
        // complete the access, so the timeout still aborts it.
        if (bus_gnt && r_we) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else if (bus_gnt) begin
          w_next = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        w_stall = 1'b1;
        if (bus_rvalid) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_unit  <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_abort;
      if (r_state == S_IDLE && w_req && !w_misal) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_unit  <= MemUnit;
        r_we    <= MemWrite;
        r_cnt   <= '0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT_R) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_WAIT_R && bus_rvalid) begin
        r_rdata <= w_ext;
      end else if (w_abort && !r_we) begin
        r_rdata <= '0;
      end
    end
  end

  assign rdata     = r_rdata;
  assign stall     = w_stall;
  assign misalign  = w_misalign;
  assign bus_err   = r_err;
  assign bus_req   = w_bus_req;
  assign bus_we    = w_bus_req & r_we;
  assign bus_addr  = w_bus_req ? {r_addr[31:2], 2'b00} : '0;
  assign bus_be    = w_bus_req ? w_be : '0;
  assign bus_wdata = (w_bus_req && r_we) ? w_bwdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with hand-computed expected values.
//   The DUT is built with TIMEOUT=8 so the abort path is reachable quickly.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemUnit;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int unsigned n_cmp;
  int unsigned n_err;

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemUnit    (MemUnit),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Store with the grant arriving gnt_delay cycles into ISSUE.
  task automatic do_store(input string tag, input logic [2:0] unit, input logic [31:0] a,
                          input logic [31:0] d, input int gnt_delay,
                          input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                          input logic [31:0] exp_bwd, input int exp_stall,
                          input logic [31:0] exp_rdata);
    int nstall;
    MemWrite = 1'b1; MemUnit = unit; addr = a; wdata = d;
    #1;
    check({tag, " idle stall"}, 32'(stall), 32'd1);
    check({tag, " idle bus_req"}, 32'(bus_req), 32'd0);
    nstall = 1;
    step();
    MemWrite = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    check({tag, " bus_req"}, 32'(bus_req), 32'd1);
    check({tag, " bus_we"}, 32'(bus_we), 32'd1);
    check({tag, " bus_addr"}, bus_addr, exp_baddr);
    check({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
    check({tag, " bus_wdata"}, bus_wdata, exp_bwd);
    for (int k = 0; k < 20; k++) begin
      if (!stall) break;
      nstall++;
      if (k == gnt_delay) bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
    end
    check({tag, " stall cycles"}, 32'(nstall), 32'(exp_stall));
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " done bus_err"}, 32'(bus_err), 32'd0);
    check({tag, " done bus_req"}, 32'(bus_req), 32'd0);
    check({tag, " rdata kept"}, rdata, exp_rdata);
    step();
  endtask

  // Load with immediate grant and read data one cycle later.
  task automatic do_load(input string tag, input logic [2:0] unit, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp_baddr,
                         input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    MemRead = 1'b1; MemUnit = unit; addr = a;
    #1;
    check({tag, " idle stall"}, 32'(stall), 32'd1);
    check({tag, " idle misalign"}, 32'(misalign), 32'd0);
    step();
    MemRead = 1'b0; addr = 32'h0;
    check({tag, " bus_req"}, 32'(bus_req), 32'd1);
    check({tag, " bus_we"}, 32'(bus_we), 32'd0);
    check({tag, " bus_addr"}, bus_addr, exp_baddr);
    check({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
    bus_gnt = 1'b1;
    bus_rvalid = 1'b1;          // ignored while in ISSUE
    bus_rdata = 32'h5555_5555;
    step();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    check({tag, " wait bus_req"}, 32'(bus_req), 32'd0);
    check({tag, " wait stall"}, 32'(stall), 32'd1);
    bus_rvalid = 1'b1;
    bus_rdata = word;
    step();
    bus_rvalid = 1'b0;
    bus_rdata = 32'h0;
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " done bus_err"}, 32'(bus_err), 32'd0);
    check({tag, " rdata"}, rdata, exp_rdata);
    step();
    check({tag, " rdata hold"}, rdata, exp_rdata);
  endtask

  // Misaligned/illegal request: one-cycle flag, no stall, no bus activity.
  task automatic do_misal(input string tag, input logic rd, input logic wr,
                          input logic [2:0] unit, input logic [31:0] a,
                          input logic [31:0] exp_rdata);
    MemRead = rd; MemWrite = wr; MemUnit = unit; addr = a;
    #1;
    check({tag, " misalign"}, 32'(misalign), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " bus_req"}, 32'(bus_req), 32'd0);
    step();
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check({tag, " misalign gone"}, 32'(misalign), 32'd0);
    check({tag, " bus_req after"}, 32'(bus_req), 32'd0);
    check({tag, " rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    int nissue;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemUnit = 3'd0;
    addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst rdata", rdata, 32'h0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst misalign", 32'(misalign), 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst bus_wdata", bus_wdata, 32'h0);

    do_store("SW", 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1,
             32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 3, 32'h0);

    do_load("LB",  3'd0, 32'h0000_0301, 32'h1234_80FF, 32'h0000_0300, 4'b0010, 32'hFFFF_FF80);
    do_load("LBU", 3'd4, 32'h0000_0301, 32'h1234_80FF, 32'h0000_0300, 4'b0010, 32'h0000_0080);
    do_load("LH",  3'd1, 32'h0000_0302, 32'h8001_1234, 32'h0000_0300, 4'b1100, 32'hFFFF_8001);
    do_load("LHU", 3'd5, 32'h0000_0302, 32'h8001_1234, 32'h0000_0300, 4'b1100, 32'h0000_8001);
    do_load("LW",  3'd2, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D);

    do_store("SB", 3'd0, 32'h0000_0203, 32'h0000_00A5, 0,
             32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 2, 32'hCAFE_F00D);
    do_store("SH", 3'd1, 32'h0000_0200, 32'h1234_BEEF, 0,
             32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 2, 32'hCAFE_F00D);

    do_misal("LW@102", 1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'hCAFE_F00D);
    do_misal("SH@101", 1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'hCAFE_F00D);
    do_misal("RD+WR",  1'b1, 1'b1, 3'd0, 32'h0000_0100, 32'hCAFE_F00D);
    do_misal("unit3",  1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'hCAFE_F00D);
    do_misal("unit7",  1'b0, 1'b1, 3'd7, 32'h0000_0100, 32'hCAFE_F00D);

    // Timeout: load never granted.
    step();
    MemRead = 1'b1; MemUnit = 3'd2; addr = 32'h0000_0400;
    step();
    MemRead = 1'b0;
    nissue = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus_req) break;
      nissue++;
      step();
    end
    check("TO issue cycles", 32'(nissue), 32'd8);
    check("TO bus_err", 32'(bus_err), 32'd1);
    check("TO stall", 32'(stall), 32'd0);
    check("TO rdata", rdata, 32'h0);
    bus_gnt = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h1111_1111;
    step();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    check("TO late bus_err", 32'(bus_err), 32'd0);
    check("TO late bus_req", 32'(bus_req), 32'd0);
    check("TO late stall", 32'(stall), 32'd0);
    check("TO late rdata", rdata, 32'h0);
    step();

    // Reset asserted while waiting for read data.
    do_load("LB2", 3'd0, 32'h0000_0301, 32'h1234_80FF, 32'h0000_0300, 4'b0010, 32'hFFFF_FF80);
    MemRead = 1'b1; MemUnit = 3'd2; addr = 32'h0000_0500;
    step();
    MemRead = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("RST wait bus_req", 32'(bus_req), 32'd0);
    check("RST wait stall", 32'(stall), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("RST bus_req", 32'(bus_req), 32'd0);
    check("RST stall", 32'(stall), 32'd0);
    check("RST rdata", rdata, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata = 32'h7777_7777;
    step();
    bus_rvalid = 1'b0;
    reset = 1'b0;
    step();
    check("RST after bus_req", 32'(bus_req), 32'd0);
    check("RST after stall", 32'(stall), 32'd0);
    check("RST after bus_err", 32'(bus_err), 32'd0);
    check("RST after rdata", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
